// File: rtl/keypad_scan_if.sv
// Key-event channel between keypad_scan (master) and its CPU/MMIO consumer (slave).
interface keypad_scan_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    modport master (output key_code, key_valid, key_down, overrun, input key_ack);
    modport slave  (input key_code, key_valid, key_down, overrun, output key_ack);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame debounce and a valid/ack key-event channel.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_PERIOD    = 200000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    row_in,
    output logic [3:0]    col_out,
    keypad_scan_if.master kif
);
    localparam int unsigned TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [3:0]  DB = 4'(DEBOUNCE_SCANS);

    if (SCAN_PERIOD < 1 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_scan
        $error("keypad_scan: SCAN_PERIOD must be >=1 and DEBOUNCE_SCANS within 1..15");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_scan: REPEAT_DELAY and REPEAT_RATE must be >=1");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE_DB} state_e;

    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    hit_code_q, hit_code_d;
    state_e        state_q, state_d;
    logic [3:0]    cand_q, cand_d, cnt_q, cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d, key_down_q, key_down_d, overrun_q, overrun_d;

    logic          tick, frame_done, frame_single, frame_none, post;
    logic [1:0]    col_hits, col_row, tot_hits;
    logic [2:0]    hit_sum;
    logic [3:0]    merged_code, post_code, cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic          rep_first_q, rep_first_d;
`endif

    always_comb begin
        sync1_d    = row_in;
        sync2_d    = sync1_q;
        tick       = (tick_cnt_q == TW'(SCAN_PERIOD - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        col_d      = col_q;
        col_out_d  = col_out_q;
        hits_d     = hits_q;
        hit_code_d = hit_code_q;

        // Per-column low count saturates at 2: anything above one hit is a ghost frame.
        col_hits = '0;
        col_row  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!sync2_q[r]) begin
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                col_row = 2'(r);
            end
        end
        hit_sum      = {1'b0, hits_q} + {1'b0, col_hits};
        tot_hits     = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_code  = (col_hits != '0) ? {col_row, col_q} : hit_code_q;
        frame_done   = tick && (col_q == 2'd3);
        frame_single = frame_done && (tot_hits == 2'd1);
        frame_none   = frame_done && (tot_hits != 2'd1);

        if (tick) begin
            col_d     = col_q + 2'd1;
            col_out_d = ~(4'b0001 << col_d);
            if (frame_done) begin
                hits_d     = '0;
                hit_code_d = '0;
            end else begin
                hits_d     = tot_hits;
                hit_code_d = merged_code;
            end
        end

        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 4'd1;
        post      = 1'b0;
        post_code = cand_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_inc     = rep_cnt_q + RW'(1);
`endif

        unique case (state_q)
            IDLE: if (frame_single) begin
                cand_d = merged_code;
                cnt_d  = 4'd1;
                if (DB == 4'd1) begin
                    post      = 1'b1;
                    post_code = merged_code;
                    state_d   = PRESSED;
                end else begin
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: if (frame_single && merged_code == cand_q) begin
                cnt_d = cnt_inc;
                if (cnt_inc == DB) begin
                    post    = 1'b1;
                    state_d = PRESSED;
                end
            end else if (frame_done) begin
                state_d = IDLE;
            end
            PRESSED: if (frame_none) begin
                cnt_d   = 4'd1;
                state_d = (DB == 4'd1) ? IDLE : RELEASE_DB;
            end else if (frame_single && merged_code == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
                if (rep_first_q ? (rep_inc == RW'(REPEAT_DELAY)) : (rep_inc == RW'(REPEAT_RATE))) begin
                    post        = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_inc;
                end
`endif
            end
            RELEASE_DB: if (frame_none) begin
                cnt_d = cnt_inc;
                if (cnt_inc == DB) state_d = IDLE;
            end else if (frame_single) begin
                if (merged_code == cand_q) state_d = PRESSED;
                else cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

`ifdef KEYPAD_REPEAT_EN
        if (state_d != PRESSED) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end
`endif
        key_down_d = (state_d == PRESSED) || (state_d == RELEASE_DB);

        // An ack in the same cycle as a new event frees the slot, so the event loads without overrun.
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (key_valid_q && kif.key_ack) begin
            key_valid_d = post;
            overrun_d   = 1'b0;
            if (post) key_code_d = post_code;
        end else if (key_valid_q) begin
            if (post) overrun_d = 1'b1;
        end else if (post) begin
            key_valid_d = 1'b1;
            key_code_d  = post_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            tick_cnt_q  <= '0;
            col_q       <= '0;
            col_out_q   <= 4'b1110;
            hits_q      <= '0;
            hit_code_q  <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_cnt_q  <= tick_cnt_d;
            col_q       <= col_d;
            col_out_q   <= col_out_d;
            hits_q      <= hits_d;
            hit_code_q  <= hit_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign col_out       = col_out_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_down  = key_down_q;
    assign kif.overrun   = overrun_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: keypad matrix model, event scoreboard, frame-aligned timing checks.
module tb_keypad_scan;
    localparam int unsigned SP = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned RD = 5;
    localparam int unsigned RR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] pressed;
    int          cyc;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_q[$];
    int          exp_cyc[$];

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_PERIOD(SP), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .kif(kif)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                if (pressed[r*4+c] && col_out[c] === 1'b0) row_in[r] = 1'b0;
    end

    // cyc = index of the current cycle since reset release; frame n completes in cycle 16n-1.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic do_reset;
        rst = 1'b1;
        pressed = '0;
        kif.key_ack = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] one;
        logic [3:0] exp_col;
        one = 4'b0001;
        rst = 1'b1;
        pressed = '0;
        kif.key_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({col_out, kif.key_code, kif.key_valid, kif.key_down, kif.overrun} !== {4'b1110, 4'h0, 3'b000})
            $display("FAIL reset_state: got col=%b code=%h v=%b d=%b o=%b expected col=1110 code=0 v=0 d=0 o=0",
                     col_out, kif.key_code, kif.key_valid, kif.key_down, kif.overrun);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(one << (i / 4));
            n_checks++;
            if (col_out !== exp_col)
                $display("FAIL idle_col_out cyc %0d: got %b expected %b", i, col_out, exp_col);
            else n_pass++;
            n_checks++;
            if ({kif.key_valid, kif.key_down} !== 2'b00)
                $display("FAIL idle_quiet cyc %0d: got valid=%b down=%b expected 0 0", i, kif.key_valid, kif.key_down);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_single_press;
        int e;
        do_reset();
        pressed[9] = 1'b1;
        exp_q.push_back(9);
        wait_cyc(47);
        n_checks++;
        if (kif.key_valid !== 1'b0) $display("FAIL press_not_early: got valid=%b expected 0", kif.key_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (kif.key_valid !== 1'b1) $display("FAIL press_valid: got %b expected 1", kif.key_valid);
        else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if (int'(kif.key_code) !== e) $display("FAIL press_code: got %0d expected %0d", kif.key_code, e);
        else n_pass++;
        n_checks++;
        if (kif.key_down !== 1'b1) $display("FAIL press_down: got %b expected 1", kif.key_down);
        else n_pass++;
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
        n_checks++;
        if ({kif.key_valid, kif.overrun} !== 2'b00)
            $display("FAIL press_ack_clear: got valid=%b ovr=%b expected 0 0", kif.key_valid, kif.overrun);
        else n_pass++;
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({kif.key_valid, kif.overrun, kif.key_code} !== {2'b00, 4'd9})
            $display("FAIL idle_ack_ignored: got valid=%b ovr=%b code=%0d expected 0 0 9",
                     kif.key_valid, kif.overrun, kif.key_code);
        else n_pass++;
    endtask

    task automatic test_bounce;
        bit early;
        bit extra;
        int e;
        do_reset();
        exp_q.push_back(6);
        early = 1'b0;
        while (cyc < 96) begin
            pressed = (cyc < 32 || cyc >= 48) ? 16'h0040 : 16'h0000;
            if (kif.key_valid) early = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (early) $display("FAIL bounce_early: got early event expected none before cycle 96");
        else n_pass++;
        n_checks++;
        if (kif.key_valid !== 1'b1) $display("FAIL bounce_valid: got %b expected 1", kif.key_valid);
        else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if (int'(kif.key_code) !== e) $display("FAIL bounce_code: got %0d expected %0d", kif.key_code, e);
        else n_pass++;
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
        extra = 1'b0;
        while (cyc < 144) begin
            if (kif.key_valid) extra = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (extra) $display("FAIL bounce_single_event: got extra event expected exactly one");
        else n_pass++;
    endtask

    task automatic test_ghost;
        bit bad;
        do_reset();
        pressed = 16'h0021;
        bad = 1'b0;
        while (cyc < 96) begin
            if (kif.key_valid || kif.key_down) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) $display("FAIL ghost_reject: got event/key_down expected none");
        else n_pass++;
    endtask

    task automatic test_overrun;
        int e;
        do_reset();
        pressed = 16'h0008;
        exp_q.push_back(3);
        wait_cyc(48);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if ({kif.key_valid, 28'(0)} !== {1'b1, 28'(0)} || int'(kif.key_code) !== e)
            $display("FAIL ovr_first: got valid=%b code=%0d expected 1 %0d", kif.key_valid, kif.key_code, e);
        else n_pass++;
        pressed = '0;
        wait_cyc(95);
        n_checks++;
        if (kif.key_down !== 1'b1) $display("FAIL release_hold_down: got %b expected 1", kif.key_down);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (kif.key_down !== 1'b0) $display("FAIL release_down_clear: got %b expected 0", kif.key_down);
        else n_pass++;
        pressed = 16'h0080;
        wait_cyc(143);
        n_checks++;
        if (kif.overrun !== 1'b0) $display("FAIL ovr_not_early: got %b expected 0", kif.overrun);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({kif.key_valid, kif.overrun, kif.key_code} !== {2'b11, 4'd3})
            $display("FAIL ovr_drop: got valid=%b ovr=%b code=%0d expected 1 1 3",
                     kif.key_valid, kif.overrun, kif.key_code);
        else n_pass++;
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
        n_checks++;
        if ({kif.key_valid, kif.overrun} !== 2'b00)
            $display("FAIL ovr_ack_clear: got valid=%b ovr=%b expected 0 0", kif.key_valid, kif.overrun);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int e;
        do_reset();
        pressed = 16'h0400;
        exp_q.push_back(10);
        exp_q.push_back(15);
        wait_cyc(48);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if (kif.key_valid !== 1'b1 || int'(kif.key_code) !== e)
            $display("FAIL b2b_first: got valid=%b code=%0d expected 1 %0d", kif.key_valid, kif.key_code, e);
        else n_pass++;
        pressed = '0;
        wait_cyc(96);
        pressed = 16'h8000;
        wait_cyc(143);
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_checks++;
        if ({kif.key_valid, kif.overrun} !== 2'b10 || int'(kif.key_code) !== e)
            $display("FAIL b2b_ack_and_event: got valid=%b ovr=%b code=%0d expected 1 0 %0d",
                     kif.key_valid, kif.overrun, kif.key_code, e);
        else n_pass++;
    endtask

    task automatic test_repeat;
        int e;
        do_reset();
        pressed = 16'h0200;
        exp_cyc.push_back(48);
`ifdef KEYPAD_REPEAT_EN
        exp_cyc.push_back(128);
        exp_cyc.push_back(160);
        exp_cyc.push_back(192);
`endif
        while (cyc < 208) begin
            if (kif.key_valid && !kif.key_ack) begin
                e = (exp_cyc.size() > 0) ? exp_cyc.pop_front() : -1;
                n_checks++;
                if (cyc !== e || kif.key_code !== 4'd9)
                    $display("FAIL repeat_event: got cycle %0d code %0d expected cycle %0d code 9", cyc, kif.key_code, e);
                else n_pass++;
                kif.key_ack = 1'b1;
            end else begin
                kif.key_ack = 1'b0;
            end
            @(negedge clk);
        end
        kif.key_ack = 1'b0;
        n_checks++;
        if (exp_cyc.size() != 0) $display("FAIL repeat_missing: got %0d events missing expected 0", exp_cyc.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ghost();
        test_overrun();
        test_back_to_back();
        test_repeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
